// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register select codes, ERET funct code and Status/Cause bit positions
package cp0_pkg;
   typedef enum logic [1:0] {
      SEL_EPC    = 2'b00,
      SEL_STATUS = 2'b01,
      SEL_CAUSE  = 2'b10,
      SEL_NONE   = 2'b11
   } sel_e;
   localparam logic [5:0] FUNCT_ERET = 6'b011000;
   localparam int ST_IE = 0;
   localparam int ST_MASK_LSB = 1;
   localparam int CAUSE_PEND_LSB = 0;
   localparam int NSRC = 3;
endpackage

// File: rtl/cp0_prio_enc.sv
// cp0_prio_enc: 3-input priority encoder, highest index wins, yielding source index and handler vector
module cp0_prio_enc
   import cp0_pkg::*;
#(
   parameter logic [31:0] VEC0 = 32'h0000_1000,
   parameter logic [31:0] VEC1 = 32'h0000_1100,
   parameter logic [31:0] VEC2 = 32'h0000_1200
) (
   input  logic [NSRC-1:0] i_req,
   output logic [1:0]      o_idx,
   output logic [31:0]     o_vec
);
   assign o_idx = i_req[2] ? 2'd2 : i_req[1] ? 2'd1 : 2'd0;
   assign o_vec = i_req[2] ? VEC2 : i_req[1] ? VEC1 : VEC0;
endmodule

// File: rtl/cp0.sv
// cp0: coprocessor-0 exception/interrupt unit holding EPC, Status and Cause
module cp0
   import cp0_pkg::*;
#(
   parameter logic [31:0] VEC0 = 32'h0000_1000,
   parameter logic [31:0] VEC1 = 32'h0000_1100,
   parameter logic [31:0] VEC2 = 32'h0000_1200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Inst,
   input  logic        enable,
   input  logic [31:0] Din,
   input  logic [31:0] PCin,
   input  logic        ExpSrc0,
   input  logic        ExpSrc1,
   input  logic        ExpSrc2,
   output logic        ExRegWrite,
   output logic        IsEret,
   output logic        HasExp,
   output logic        ExpBlock,
   output logic [31:0] PCout,
   output logic [31:0] Dout
);
   logic [31:0]     r_epc;
   logic            r_ie;
   logic [NSRC-1:0] r_mask;
   logic [NSRC-1:0] r_pend;
   logic            r_blk;
   sel_e            w_sel;
   logic [NSRC-1:0] w_req;
   logic [NSRC-1:0] w_src;
   logic [NSRC-1:0] w_clr;
   logic [NSRC-1:0] w_pend_wr;
   logic [1:0]      w_idx;
   logic [31:0]     w_vec;
   logic            w_take;
   logic            w_unused;

   assign w_sel      = sel_e'(Inst[12:11]);
   assign w_src      = {ExpSrc2, ExpSrc1, ExpSrc0};
   assign w_req      = r_pend & r_mask;
   assign ExRegWrite = (Inst[25:21] == 5'b00000);
   assign IsEret     = (Inst[5:0] == FUNCT_ERET);
   assign ExpBlock   = r_blk;
   assign HasExp     = r_ie & ~r_blk & |w_req;
   // a forced eret/exception overlap resolves to the eret: redirect to EPC, nothing taken
   assign w_take     = HasExp & ~IsEret;
   assign w_clr      = w_take ? (3'b001 << w_idx) : 3'b000;
   assign w_pend_wr  = (enable && w_sel == SEL_CAUSE) ? Din[CAUSE_PEND_LSB +: NSRC] : r_pend;
   assign PCout      = IsEret ? r_epc : w_vec;
   assign Dout       = (w_sel == SEL_EPC)    ? r_epc :
                       (w_sel == SEL_STATUS) ? {28'd0, r_mask, r_ie} :
                       (w_sel == SEL_CAUSE)  ? {29'd0, r_pend} : 32'd0;
   assign w_unused   = ^{Inst[31:26], Inst[20:13], Inst[10:6], Din[31:4]};

   cp0_prio_enc #(.VEC0(VEC0), .VEC1(VEC1), .VEC2(VEC2)) u_enc (
      .i_req(w_req),
      .o_idx(w_idx),
      .o_vec(w_vec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_epc  <= 32'd0;
         r_ie   <= 1'b1;
         r_mask <= 3'b111;
         r_pend <= 3'b000;
         r_blk  <= 1'b0;
      end else begin
         r_epc  <= w_take ? PCin : (enable && w_sel == SEL_EPC) ? Din : r_epc;
         r_ie   <= (enable && w_sel == SEL_STATUS) ? Din[ST_IE] : r_ie;
         r_mask <= (enable && w_sel == SEL_STATUS) ? Din[ST_MASK_LSB +: NSRC] : r_mask;
         r_pend <= (w_pend_wr & ~w_clr) | w_src;
         r_blk  <= IsEret ? 1'b0 : w_take ? 1'b1 : r_blk;
      end
   end
endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed vector table plus randomized run against a register-level reference model
module tb_cp0;
   localparam logic [31:0] V0 = 32'h0000_1000;
   localparam logic [31:0] V1 = 32'h0000_1100;
   localparam logic [31:0] V2 = 32'h0000_1200;
   localparam logic [31:0] I_EPC = 32'h0000_0000;
   localparam logic [31:0] I_ST  = 32'h0000_0800;
   localparam logic [31:0] I_CA  = 32'h0000_1000;
   localparam logic [31:0] I_NO  = 32'h0000_1800;
   localparam logic [31:0] I_ER  = 32'h4200_0018;

   logic clk = 0, rst = 0, enable = 0, s0 = 0, s1 = 0, s2 = 0;
   logic [31:0] Inst = 0, Din = 0, PCin = 0;
   logic ExRegWrite, IsEret, HasExp, ExpBlock;
   logic [31:0] PCout, Dout;
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   cp0 dut (
      .clk(clk), .rst(rst), .Inst(Inst), .enable(enable), .Din(Din), .PCin(PCin),
      .ExpSrc0(s0), .ExpSrc1(s1), .ExpSrc2(s2),
      .ExRegWrite(ExRegWrite), .IsEret(IsEret), .HasExp(HasExp), .ExpBlock(ExpBlock),
      .PCout(PCout), .Dout(Dout)
   );

   typedef struct {
      logic        rst;
      logic [31:0] inst;
      logic        en;
      logic [31:0] din;
      logic [31:0] pcin;
      logic [2:0]  src;
      logic [31:0] dout;
      logic        has;
      logic        blk;
      logic        chk_pc;
      logic [31:0] pc;
   } vec_t;
   vec_t tv[$];

   task automatic add(input logic r, input logic [31:0] inst, input logic en, input logic [31:0] din,
                      input logic [31:0] pcin, input logic [2:0] src, input logic [31:0] dout,
                      input logic has, input logic blk, input logic cpc, input logic [31:0] pc);
      vec_t v;
      v = '{r, inst, en, din, pcin, src, dout, has, blk, cpc, pc};
      tv.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] inst, input logic en, input logic [31:0] din,
                        input logic [31:0] pcin, input logic [2:0] src);
      rst = r; Inst = inst; enable = en; Din = din; PCin = pcin;
      {s2, s1, s0} = src;
   endtask

   // reference model state: whole registers, updated by the architectural rules
   logic [31:0] m_epc, m_status, m_cause;
   logic        m_blk;
   logic [31:0] vecs[3];

   function automatic int top_src(input logic [31:0] req);
      for (int i = 2; i >= 0; i--) if (req[i]) return i;
      return 0;
   endfunction

   initial begin
      logic [31:0] inst, din, pcin, req, e_pc;
      logic en, r, m_has, m_eret;
      logic [2:0] src;
      int sel, k;
      vecs[0] = V0; vecs[1] = V1; vecs[2] = V2;
      add(0, I_ST, 0, 0, 0, 3'b000, 32'hF, 0, 0, 0, 0);
      add(0, I_CA, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      add(0, I_EPC, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      add(0, I_NO, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      add(0, I_CA, 0, 0, 32'h0040_0000, 3'b010, 0, 0, 0, 0, 0);
      add(0, I_CA, 0, 0, 32'h0040_0000, 3'b000, 2, 1, 0, 1, V1);
      add(0, I_EPC, 0, 0, 0, 3'b000, 32'h0040_0000, 0, 1, 0, 0);
      add(0, I_CA, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0);
      add(0, I_EPC, 1, 32'h1234_5678, 0, 3'b000, 32'h0040_0000, 0, 1, 0, 0);
      add(0, I_EPC, 0, 0, 0, 3'b000, 32'h1234_5678, 0, 1, 0, 0);
      add(0, I_ER, 0, 0, 0, 3'b000, 32'h1234_5678, 0, 1, 1, 32'h1234_5678);
      add(0, I_CA, 0, 0, 0, 3'b101, 0, 0, 0, 0, 0);
      add(0, I_CA, 0, 0, 32'h500, 3'b000, 5, 1, 0, 1, V2);
      add(0, I_CA, 0, 0, 0, 3'b000, 1, 0, 1, 0, 0);
      add(0, I_ER, 0, 0, 0, 3'b000, 32'h500, 0, 1, 1, 32'h500);
      add(0, I_CA, 0, 0, 32'h600, 3'b000, 1, 1, 0, 1, V0);
      add(0, I_CA, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0);
      add(0, I_ER, 0, 0, 0, 3'b000, 32'h600, 0, 1, 1, 32'h600);
      add(0, I_ST, 1, 32'hFFFF_FFFD, 0, 3'b000, 32'hF, 0, 0, 0, 0);
      add(0, I_ST, 0, 0, 0, 3'b001, 32'hD, 0, 0, 0, 0);
      add(0, I_CA, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0);
      add(0, I_ST, 1, 32'hF, 0, 3'b000, 32'hD, 0, 0, 0, 0);
      add(0, I_CA, 0, 0, 32'h700, 3'b000, 1, 1, 0, 1, V0);
      add(0, I_CA, 0, 0, 0, 3'b100, 0, 0, 1, 0, 0);
      add(0, I_CA, 0, 0, 0, 3'b000, 4, 0, 1, 0, 0);
      add(0, I_ER, 0, 0, 0, 3'b000, 32'h700, 0, 1, 1, 32'h700);
      add(0, I_CA, 0, 0, 32'h800, 3'b000, 4, 1, 0, 1, V2);
      add(0, I_EPC, 0, 0, 0, 3'b000, 32'h800, 0, 1, 0, 0);
      add(0, I_CA, 1, 32'h7, 0, 3'b000, 0, 0, 1, 0, 0);
      add(0, I_CA, 1, 32'h0, 0, 3'b001, 7, 0, 1, 0, 0);
      add(0, I_CA, 0, 0, 0, 3'b000, 1, 0, 1, 0, 0);
      add(0, I_ER, 0, 0, 0, 3'b000, 32'h800, 0, 1, 1, 32'h800);
      add(0, I_EPC, 1, 32'hDEAD_0000, 32'h900, 3'b000, 32'h800, 1, 0, 1, V0);
      add(0, I_EPC, 0, 0, 0, 3'b000, 32'h900, 0, 1, 0, 0);
      add(0, I_CA, 0, 0, 0, 3'b110, 0, 0, 1, 0, 0);
      add(1, I_CA, 0, 0, 0, 3'b000, 6, 0, 1, 0, 0);
      add(0, I_ST, 0, 0, 0, 3'b000, 32'hF, 0, 0, 0, 0);
      add(0, I_CA, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      add(0, I_EPC, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);

      drive(1, I_ST, 0, 0, 0, 3'b000);
      @(posedge clk); #1;
      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].rst, tv[i].inst, tv[i].en, tv[i].din, tv[i].pcin, tv[i].src);
         #2;
         chk($sformatf("v%0d Dout", i), Dout, tv[i].dout);
         chk($sformatf("v%0d HasExp", i), {31'd0, HasExp}, {31'd0, tv[i].has});
         chk($sformatf("v%0d ExpBlock", i), {31'd0, ExpBlock}, {31'd0, tv[i].blk});
         chk($sformatf("v%0d ExRegWrite", i), {31'd0, ExRegWrite}, {31'd0, tv[i].inst[25:21] == 5'd0});
         chk($sformatf("v%0d IsEret", i), {31'd0, IsEret}, {31'd0, tv[i].inst[5:0] == 6'b011000});
         if (tv[i].chk_pc) chk($sformatf("v%0d PCout", i), PCout, tv[i].pc);
         @(posedge clk); #1;
      end

      drive(1, I_ST, 0, 0, 0, 3'b000);
      @(posedge clk); #1;
      m_epc = 0; m_status = 32'hF; m_cause = 0; m_blk = 0;
      for (int c = 0; c < 3000; c++) begin
         inst = $urandom;
         if ($urandom_range(1, 0) == 1) inst[25:21] = 5'd0;
         if ($urandom_range(5, 0) == 0) inst[5:0] = 6'b011000;
         en = ($urandom_range(3, 0) == 0);
         din = $urandom;
         if ($urandom_range(1, 0) == 1) din[3:0] = 4'hF;
         pcin = $urandom;
         src = ($urandom_range(3, 0) == 0) ? 3'($urandom) : 3'b000;
         r = ($urandom_range(199, 0) == 0);
         drive(r, inst, en, din, pcin, src);
         #2;
         sel = int'(inst[12:11]);
         req = m_cause & (m_status >> 1) & 32'h7;
         m_has = m_status[0] && !m_blk && req != 0;
         m_eret = inst[5:0] == 6'b011000;
         k = top_src(req);
         chk("rnd Dout", Dout, sel == 0 ? m_epc : sel == 1 ? m_status : sel == 2 ? m_cause : 32'd0);
         chk("rnd HasExp", {31'd0, HasExp}, {31'd0, m_has});
         chk("rnd ExpBlock", {31'd0, ExpBlock}, {31'd0, m_blk});
         chk("rnd ExRegWrite", {31'd0, ExRegWrite}, {31'd0, inst[25:21] == 5'd0});
         chk("rnd IsEret", {31'd0, IsEret}, {31'd0, m_eret});
         if (m_eret || m_has) begin
            e_pc = m_eret ? m_epc : vecs[k];
            chk("rnd PCout", PCout, e_pc);
         end
         if (r) begin
            m_epc = 0; m_status = 32'hF; m_cause = 0; m_blk = 0;
         end else begin
            if (m_has && !m_eret) m_epc = pcin;
            else if (en && sel == 0) m_epc = din;
            if (en && sel == 1) m_status = din & 32'hF;
            if (en && sel == 2) m_cause = din & 32'h7;
            if (m_has && !m_eret) begin
               m_cause[k] = 1'b0;
               m_blk = 1'b1;
            end
            m_cause = m_cause | {29'd0, src};
            if (m_eret) m_blk = 1'b0;
         end
         @(posedge clk); #1;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
